svc_rv_bpred_dyn: RTL and testbench
===================================

# svc_rv_bpred_dyn

Dynamic branch predictor for the pipelined RV core, with a direct-mapped BTB and a 2-bit-counter BHT. The IF stage looks up the current PC and gets a taken/target prediction in the same cycle. The EX stage writes back resolved branch and jump outcomes, and mispredictions are counted. It replaces static backward-taken prediction in the `BPRED=1` configuration of the SRAM SoC.

## Interface
- `XLEN`, 32, address/data width
- `BHT_AW`, 6, log2 of entry count shared by BHT and BTB; 2^BHT_AW entries
- `GHR_W`, 6, global history width; must satisfy GHR_W <= BHT_AW

Ports:
- `clk` in 1 — clock
- `rst` in 1 — asynchronous, active-high reset
- `clr` in 1 — synchronous invalidate of all state (fence.i)
- `lk_pc` in XLEN — IF-stage PC to predict
- `pred_taken` out 1 — predict taken
- `pred_target` out XLEN — predicted target; valid only when pred_taken=1
- `pred_ghr` out GHR_W — history snapshot, carried down the pipe by the core
- `upd_valid` in 1 — one resolved control-flow instruction this cycle
- `upd_pc` in XLEN — PC of the resolved instruction
- `upd_is_branch` in 1 — 1 for conditional branch, 0 for JAL
- `upd_taken` in 1 — actual outcome
- `upd_target` in XLEN — actual target
- `upd_mispred` in 1 — core detected a misprediction
- `upd_ghr` in GHR_W — pred_ghr value captured when this instruction was looked up
- `stat_updates` out 32 — count of upd_valid cycles
- `stat_mispred` out 32 — count of upd_valid && upd_mispred cycles

## Operation
- Index: idx = pc[BHT_AW+1:2]. Tag: pc[XLEN-1:BHT_AW+2].
- Per entry: 2-bit counter ctr (00 SNT, 01 WNT, 10 WT, 11 ST), BTB valid bit, tag, target[XLEN-1:2]. The low 2 bits of the target are always 0.
- Lookup is combinational from the registered arrays:
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = {target[idx], 2'b00}.
- Branch update (upd_valid, upd_is_branch=1):
  - ctr increments on taken and decrements on not-taken, saturating at 11 and 00.
  - If taken: BTB entry is written (valid=1, tag, target).
  - If not taken: BTB entry is left unchanged.
- JAL update (upd_valid, upd_is_branch=0):
  - BTB entry is written.
  - ctr is forced to 11.
  - GHR is unchanged.
- Allocation on a tag mismatch overwrites the entry and resets ctr to 10 for a taken branch (11 for JAL).
- GHR: on a branch update, ghr <= {ghr[GHR_W-2:0], upd_taken}.
- Stats counters wrap from 0xFFFF_FFFF to 0.
- clr, for one cycle:
  - All valid bits cleared, all ctr set to 01, GHR set to 0.
  - Stats counters are not affected.
  - clr has priority over an update in the same cycle; that update is dropped but is still counted in the stats.

## Timing
- Lookup latency is 0 cycles.
- An update is written on the rising edge and becomes visible to lookups in the following cycle.
- A lookup and an update to the same index in the same cycle: the lookup sees the old contents.
- Reset values:
  - All valid=0, all ctr=01, ghr=0, stats=0.
  - Therefore pred_taken=0, pred_target=0, pred_ghr=0.
- Asserting rst mid-operation clears all state immediately. No update in flight survives.

## Configuration
- `SVC_RV_BPRED_GSHARE_EN` defined:
  - Lookup BHT index = idx XOR zero-extended ghr.
  - Update BHT index = upd idx XOR zero-extended upd_ghr.
  - pred_ghr = ghr.
  - The BTB always uses the plain idx.
- Undefined:
  - BHT index = idx.
  - The GHR register is not built, pred_ghr=0, and upd_ghr is ignored.

## Structure
- Package `svc_rv_bpred_pkg`:
  - ctr2_t typedef.
  - Constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - Function ctr2_next(ctr, taken).
- Sub-module `svc_rv_bpred_btb`: valid/tag/target storage, a combinational read port, one write port and clear.
- The BHT, GHR and stats counters live in the top module.

## Test plan
All scenarios use BHT_AW=4 and GHR_W=4.
- **Reset.** Hold rst, then lookup 0x100 → pred_taken=0, pred_target=0, stats=0.
- **Learn a taken branch.**
  - Update pc=0x104, taken, target 0x80 → the next-cycle lookup of 0x104 gives pred_taken=1, pred_target=0x80.
  - After 3 further not-taken updates → pred_taken=0, and ctr saturates at 00.
- **Alias.** After learning 0x104, a lookup of 0x144 (same idx, tag 5 vs 4) → pred_taken=0. Then a taken update of 0x144 → 0x104 now misses.
- **Same-cycle read/write.**
  - Lookup 0x104 while updating 0x104 taken from empty → pred_taken=0 in that cycle and 1 in the next.
  - clr together with an update → everything is invalid afterwards, and stat_updates still increments.
- **Stats.** 5 updates, 2 with upd_mispred → stat_updates=5, stat_mispred=2.
- **GSHARE build.**
  - 3 taken branch updates → pred_ghr=4'b0111.
  - An update at pc=0x100 with upd_ghr=3 trains BHT entry 3, not entry 0.

Source files
------------

// File: rtl/svc_rv_bpred_pkg.sv
// Shared types and helpers for the dynamic branch predictor:
// the 2-bit saturating counter encoding and its next-state function.
package svc_rv_bpred_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    // Saturating step towards the observed outcome.
    function automatic ctr2_t ctr2_next(input ctr2_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr2_t'(ctr + 2'd1);
        end else begin
            return (ctr == CTR_SNT) ? CTR_SNT : ctr2_t'(ctr - 2'd1);
        end
    endfunction

endpackage

// File: rtl/svc_rv_bpred_btb.sv
// Direct-mapped branch target buffer: per-entry valid bit, tag and
// word-aligned target. One combinational read port for IF-stage lookup,
// one write port for EX-stage resolution, plus a hit probe on the write
// address so the caller can detect allocation. clr invalidates all entries.
module svc_rv_bpred_btb #(
    parameter int XLEN = 32,
    parameter int AW   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [AW-1:0]        rd_idx,
    input  logic [XLEN-AW-3:0]   rd_tag,
    output logic                 rd_hit,
    output logic [XLEN-3:0]      rd_target,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_idx,
    input  logic [XLEN-AW-3:0]   wr_tag,
    input  logic [XLEN-3:0]      wr_target,
    output logic                 wr_hit
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0]    valid;
    logic [XLEN-AW-3:0]  tag_mem    [DEPTH];
    logic [XLEN-3:0]     target_mem [DEPTH];

    // Reads see the registered contents, so a same-cycle write is not bypassed.
    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_target = target_mem[rd_idx];
    assign wr_hit    = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    // Entry storage; tag/target are reset too so the idle target reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
            end
        end else if (clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx]      <= 1'b1;
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/svc_rv_bpred_dyn.sv
// Dynamic branch predictor: direct-mapped BTB plus a table of 2-bit
// counters (BHT), zero-cycle lookup from IF, training from EX, and
// update/mispredict statistics.
// Build option SVC_RV_BPRED_GSHARE_EN: index the BHT with pc index XOR
// global history; otherwise the history register is not built.
module svc_rv_bpred_dyn
    import svc_rv_bpred_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int BHT_AW = 6,
    parameter int GHR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [XLEN-1:0]   lk_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_mispred,
    input  logic [GHR_W-1:0]  upd_ghr,
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispred
);

    localparam int DEPTH = 1 << BHT_AW;
    localparam int TAG_W = XLEN - BHT_AW - 2;

    logic [BHT_AW-1:0] lk_idx;
    logic [BHT_AW-1:0] upd_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [TAG_W-1:0]  upd_tag;
    logic [BHT_AW-1:0] lk_bht_idx;
    logic [BHT_AW-1:0] upd_bht_idx;
    logic              btb_hit;
    logic              upd_hit;
    logic [XLEN-3:0]   btb_target;
    logic              btb_wr;
    ctr2_t             bht [DEPTH];

    assign lk_idx  = lk_pc[BHT_AW+1:2];
    assign upd_idx = upd_pc[BHT_AW+1:2];
    assign lk_tag  = lk_pc[XLEN-1:BHT_AW+2];
    assign upd_tag = upd_pc[XLEN-1:BHT_AW+2];

    // Instruction addresses are word aligned; the low bits carry nothing.
    logic unused_lsbs;
    assign unused_lsbs = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

`ifdef SVC_RV_BPRED_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    assign lk_bht_idx  = lk_idx ^ BHT_AW'(ghr);
    assign upd_bht_idx = upd_idx ^ BHT_AW'(upd_ghr);
    assign pred_ghr    = ghr;

    // Global history shifts in each resolved conditional branch outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (clr) begin
            ghr <= '0;
        end else if (upd_valid && upd_is_branch) begin
            ghr <= {ghr[GHR_W-2:0], upd_taken};
        end
    end
`else
    assign lk_bht_idx  = lk_idx;
    assign upd_bht_idx = upd_idx;
    assign pred_ghr    = '0;

    logic unused_ghr;
    assign unused_ghr = ^upd_ghr;
`endif

    // JALs always install; conditional branches only install when taken.
    assign btb_wr = upd_valid && (!upd_is_branch || upd_taken);

    svc_rv_bpred_btb #(
        .XLEN (XLEN),
        .AW   (BHT_AW)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .rd_idx    (lk_idx),
        .rd_tag    (lk_tag),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (btb_wr),
        .wr_idx    (upd_idx),
        .wr_tag    (upd_tag),
        .wr_target (upd_target[XLEN-1:2]),
        .wr_hit    (upd_hit)
    );

    assign pred_taken  = btb_hit && bht[lk_bht_idx][1];
    assign pred_target = {btb_target, 2'b00};

    // Counter training; a fresh allocation starts at weakly-taken so an
    // aliasing entry's old confidence does not leak into the new branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= CTR_WNT;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= CTR_WNT;
        end else if (upd_valid) begin
            if (!upd_is_branch) begin
                bht[upd_bht_idx] <= CTR_ST;
            end else if (upd_taken && !upd_hit) begin
                bht[upd_bht_idx] <= CTR_WT;
            end else begin
                bht[upd_bht_idx] <= ctr2_next(bht[upd_bht_idx], upd_taken);
            end
        end
    end

    // Statistics count every resolved instruction, even one dropped by clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates <= '0;
            stat_mispred <= '0;
        end else if (upd_valid) begin
            stat_updates <= stat_updates + 32'd1;
            if (upd_mispred) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_svc_rv_bpred_dyn.sv
// Self-checking bench for svc_rv_bpred_dyn (BHT_AW=4, GHR_W=4).
// Expected values are queued when stimulus is driven and popped when the
// outputs are sampled mid-cycle, away from the rising edge.
module tb_svc_rv_bpred_dyn;

    localparam int K_TAKEN  = 0;
    localparam int K_TARGET = 1;
    localparam int K_UPD    = 2;
    localparam int K_MIS    = 3;
    localparam int K_GHR    = 4;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] lk_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [3:0]  upd_ghr;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispred;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_upd;
    logic [31:0] exp_mis;

    svc_rv_bpred_dyn #(
        .XLEN   (32),
        .BHT_AW (4),
        .GHR_W  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .lk_pc         (lk_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_ghr      (pred_ghr),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_is_branch (upd_is_branch),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispred   (upd_mispred),
        .upd_ghr       (upd_ghr),
        .stat_updates  (stat_updates),
        .stat_mispred  (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_TAKEN:  return {31'b0, pred_taken};
            K_TARGET: return pred_target;
            K_UPD:    return stat_updates;
            K_MIS:    return stat_mispred;
            K_GHR:    return {28'b0, pred_ghr};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] v);
        sb.push_back('{tag, kind, v});
    endtask

    task automatic check_now();
        #2;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic no_upd();
        upd_valid     = 1'b0;
        upd_pc        = '0;
        upd_is_branch = 1'b0;
        upd_taken     = 1'b0;
        upd_target    = '0;
        upd_mispred   = 1'b0;
        upd_ghr       = '0;
    endtask

    task automatic set_upd(input logic br, input logic tk, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic mp, input logic [3:0] gh);
        upd_valid     = 1'b1;
        upd_is_branch = br;
        upd_taken     = tk;
        upd_pc        = pc;
        upd_target    = tgt;
        upd_mispred   = mp;
        upd_ghr       = gh;
    endtask

    task automatic lk(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input string tag);
        lk_pc = pc;
        push(tag, K_TAKEN, {31'b0, tk});
        if (tk) push({tag, ".tgt"}, K_TARGET, tgt);
        check_now();
    endtask

    task automatic chk_stats(input string tag);
        push({tag, ".upd"}, K_UPD, exp_upd);
        push({tag, ".mis"}, K_MIS, exp_mis);
        check_now();
    endtask

    // Advance one cycle: the stats model counts what the edge will commit.
    task automatic tick();
        if (upd_valid && !rst) begin
            exp_upd = exp_upd + 32'd1;
            if (upd_mispred) exp_mis = exp_mis + 32'd1;
        end
        @(posedge clk);
        @(negedge clk);
        no_upd();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        lk_pc = '0;
        no_upd();
        exp_upd = '0;
        exp_mis = '0;
        repeat (2) @(negedge clk);

        // Reset state
        lk_pc = 32'h100;
        push("rst_taken", K_TAKEN, 32'd0);
        push("rst_target", K_TARGET, 32'd0);
        push("rst_ghr", K_GHR, 32'd0);
        chk_stats("rst_stats");
        rst = 1'b0;
        @(negedge clk);

`ifndef SVC_RV_BPRED_GSHARE_EN
        // Learn, same-cycle read/write, saturation
        set_upd(1, 1, 32'h104, 32'h80, 0, 0); lk(32'h104, 0, 0, "rdw_old"); tick();
        lk(32'h104, 1, 32'h80, "learn_taken"); tick();
        set_upd(1, 0, 32'h104, 0, 0, 0); lk(32'h104, 1, 32'h80, "nt1"); tick();
        set_upd(1, 0, 32'h104, 0, 0, 0); lk(32'h104, 0, 0, "nt2"); tick();
        set_upd(1, 0, 32'h104, 0, 0, 0); lk(32'h104, 0, 0, "nt3"); tick();
        set_upd(1, 1, 32'h104, 32'h80, 0, 0); lk(32'h104, 0, 0, "sat_snt"); tick();
        set_upd(1, 1, 32'h104, 32'h80, 0, 0); lk(32'h104, 0, 0, "inc_to_wnt"); tick();
        lk(32'h104, 1, 32'h80, "back_to_wt"); tick();

        // Aliasing: same index, different tag
        lk(32'h144, 0, 0, "alias_miss"); tick();
        set_upd(1, 1, 32'h144, 32'h200, 1, 0); tick();
        lk(32'h104, 0, 0, "alias_evict"); tick();
        set_upd(1, 0, 32'h144, 0, 0, 0); lk(32'h144, 1, 32'h200, "alias_new"); tick();
        lk(32'h144, 0, 0, "alloc_wt"); tick();

        // JAL forces strongly taken
        set_upd(0, 1, 32'h10, 32'h300, 0, 0); tick();
        set_upd(1, 0, 32'h10, 0, 0, 0); lk(32'h10, 1, 32'h300, "jal_learn"); tick();
        lk(32'h10, 1, 32'h300, "jal_st"); tick();

        // Without gshare, upd_ghr is ignored and the history stays zero
        set_upd(1, 1, 32'h100, 32'h500, 0, 4'h3); tick();
        push("plain_ghr", K_GHR, 32'd0);
        lk(32'h100, 1, 32'h500, "plain_idx"); tick();
        chk_stats("stats_mid");
`else
        // History shifts in taken outcomes
        for (int i = 0; i < 3; i++) begin
            set_upd(1, 1, 32'h28, 32'h600, 0, 0);
            tick();
        end
        push("ghr_shift", K_GHR, 32'h7); check_now();
        clr = 1'b1; tick();
        push("ghr_clr", K_GHR, 32'h0); check_now();

        // upd_ghr=3 at pc 0x100 trains BHT entry 3
        set_upd(1, 1, 32'h100, 32'h500, 0, 4'h3); tick();
        set_upd(1, 1, 32'h28, 32'h600, 0, 0); tick();
        push("gs_ghr3", K_GHR, 32'h3);
        lk(32'h100, 1, 32'h500, "gshare_entry3"); tick();
        for (int i = 0; i < 4; i++) begin
            set_upd(1, 0, 32'h28, 0, 0, 0);
            tick();
        end
        push("gs_ghr0", K_GHR, 32'h0);
        lk(32'h100, 0, 0, "gshare_not_entry0"); tick();
        chk_stats("stats_mid");
`endif

        // clr together with an update: update dropped, still counted
        set_upd(1, 1, 32'h30, 32'h400, 1, 0);
        clr = 1'b1;
        lk(32'h30, 0, 0, "clr_same_cycle");
        tick();
        lk(32'h30, 0, 0, "clr_drop"); tick();
        lk(32'h104, 0, 0, "clr_inv_104"); tick();
        lk(32'h10, 0, 0, "clr_inv_10"); tick();
        push("clr_ghr", K_GHR, 32'd0);
        chk_stats("clr_stats");

        // Asynchronous reset mid-operation with an update in flight
        set_upd(0, 1, 32'h10, 32'h300, 0, 0); tick();
        lk(32'h10, 1, 32'h300, "pre_rst"); tick();
        set_upd(0, 1, 32'h20, 32'h700, 1, 0);
        rst = 1'b1;
        exp_upd = '0;
        exp_mis = '0;
        lk(32'h10, 0, 0, "rst_async");
        tick();
        rst = 1'b0;
        lk(32'h10, 0, 0, "post_rst_10"); tick();
        lk(32'h20, 0, 0, "post_rst_20");
        chk_stats("post_rst_stats");
        tick();

        // Stats: 5 updates, 2 mispredicted
        set_upd(1, 0, 32'h08, 0, 1, 0); tick();
        set_upd(1, 0, 32'h0C, 0, 0, 0); tick();
        set_upd(1, 1, 32'h18, 32'h40, 0, 0); tick();
        set_upd(0, 1, 32'h1C, 32'h44, 1, 0); tick();
        set_upd(1, 0, 32'h08, 0, 0, 0); tick();
        push("stats5_upd", K_UPD, 32'd5);
        push("stats5_mis", K_MIS, 32'd2);
        chk_stats("stats_model");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
